// File: rtl/arbiter_rr4_onehot.sv
// Four-requester round-robin arbiter with a one-hot grant (requester 0 -> 4'b1000).
// A grant lasts until done, until the holder drops its request, or until an optional hold timeout.
module arbiter_rr4_onehot #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant_oh,
    output logic [1:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic             HOLD_EN   = (MAX_HOLD != 0);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       ptr;
    logic [1:0]       ptr_nxt;
    logic [1:0]       holder;
    logic [1:0]       holder_nxt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_nxt;
    logic             timeout_q;
    logic             timeout_nxt;

    logic [1:0]       cand;
    logic [1:0]       pick;
    logic             pick_found;
    logic             hold_expired;

    // State register; every output is decoded from these flops only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            holder    <= 2'd0;
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            holder    <= holder_nxt;
            hold_cnt  <= hold_cnt_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    always_comb begin
        cand       = 2'd0;
        pick       = 2'd0;
        pick_found = 1'b0;
        for (int off = 0; off < 4; off++) begin
            cand = ptr + 2'(off);
            if (!pick_found && req[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    assign hold_expired = HOLD_EN && (hold_cnt == HOLD_LAST);

    // Release priority is done, then abandon, then timeout; only the last one pulses timeout.
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        holder_nxt   = holder;
        hold_cnt_nxt = hold_cnt;
        timeout_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt    = BUSY;
                    holder_nxt   = pick;
                    ptr_nxt      = pick + 2'd1;
                    hold_cnt_nxt = '0;
                end
            end
            BUSY: begin
                if (done || !req[holder] || hold_expired) begin
                    state_nxt    = IDLE;
                    holder_nxt   = 2'd0;
                    hold_cnt_nxt = '0;
                    timeout_nxt  = !done && req[holder];
                end else if (hold_cnt != '1) begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        grant_valid = (state == BUSY);
        grant_idx   = grant_valid ? holder : 2'd0;
        grant_oh    = grant_valid ? (4'b1000 >> holder) : 4'b0000;
        timeout     = timeout_q;
    end

endmodule

// File: tb/tb_arbiter_rr4_onehot.sv
// Self-checking bench for arbiter_rr4_onehot: a table of per-cycle vectors feeds a scoreboard
// queue, followed by hand-written timeout and abandon sequences.
module tb_arbiter_rr4_onehot;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] oh;
        logic [1:0] idx;
        logic       valid;
        logic       tmo;
        string      name;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant_oh;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    vec_t vecs[$];
    vec_t expq[$];
    int   checks = 0;
    int   errors = 0;

    arbiter_rr4_onehot #(
        .MAX_HOLD(4),
        .CNT_W   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .done       (done),
        .grant_oh   (grant_oh),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void addVec(input logic r, input logic [3:0] rq, input logic d,
                                   input logic [3:0] oh, input logic [1:0] idx,
                                   input logic v, input logic t, input string nm);
        vec_t e;
        e.rst = r; e.req = rq; e.done = d;
        e.oh = oh; e.idx = idx; e.valid = v; e.tmo = t; e.name = nm;
        vecs.push_back(e);
    endfunction

    task automatic checkOutput();
        vec_t e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty: got no expected entry, want one per cycle");
        end else begin
            e = expq.pop_front();
            if (grant_oh !== e.oh || grant_idx !== e.idx || grant_valid !== e.valid || timeout !== e.tmo) begin
                errors++;
                $display("[TB] FAIL %s: got oh=%b idx=%0d valid=%b timeout=%b, want oh=%b idx=%0d valid=%b timeout=%b",
                         e.name, grant_oh, grant_idx, grant_valid, timeout, e.oh, e.idx, e.valid, e.tmo);
            end
        end
    endtask

    // Drive one cycle of inputs, queue its expected outputs, then compare just after the edge.
    task automatic applyStimulus(input vec_t e);
        rst  = e.rst;
        req  = e.req;
        done = e.done;
        expq.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        int   gcnt;
        logic seen;

        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;

        addVec(1, 4'b0000, 0, 4'b0000, 0, 0, 0, "reset_0");
        addVec(1, 4'b0000, 0, 4'b0000, 0, 0, 0, "reset_1");
        addVec(0, 4'b0000, 0, 4'b0000, 0, 0, 0, "idle_noreq");
        addVec(0, 4'b0100, 0, 4'b0010, 2, 1, 0, "single_grant2");
        addVec(0, 4'b0100, 1, 4'b0000, 0, 0, 0, "single_done");
        addVec(0, 4'b0000, 0, 4'b0000, 0, 0, 0, "single_idle");
        addVec(1, 4'b1111, 0, 4'b0000, 0, 0, 0, "rr_reset");
        addVec(0, 4'b1111, 0, 4'b1000, 0, 1, 0, "rr_grant0");
        addVec(0, 4'b1111, 1, 4'b0000, 0, 0, 0, "rr_bubble0");
        addVec(0, 4'b1111, 0, 4'b0100, 1, 1, 0, "rr_grant1");
        addVec(0, 4'b1111, 1, 4'b0000, 0, 0, 0, "rr_bubble1");
        addVec(0, 4'b1111, 0, 4'b0010, 2, 1, 0, "rr_grant2");
        addVec(0, 4'b1111, 1, 4'b0000, 0, 0, 0, "rr_bubble2");
        addVec(0, 4'b1111, 0, 4'b0001, 3, 1, 0, "rr_grant3");
        addVec(0, 4'b1111, 1, 4'b0000, 0, 0, 0, "rr_bubble3");
        addVec(0, 4'b1111, 0, 4'b1000, 0, 1, 0, "rr_grant0_again");
        addVec(0, 4'b1111, 1, 4'b0000, 0, 0, 0, "rr_bubble4");
        addVec(0, 4'b0001, 0, 4'b1000, 0, 1, 0, "to_hold1");
        addVec(0, 4'b0001, 0, 4'b1000, 0, 1, 0, "to_hold2");
        addVec(0, 4'b0001, 0, 4'b1000, 0, 1, 0, "to_hold3");
        addVec(0, 4'b0001, 0, 4'b1000, 0, 1, 0, "to_hold4");
        addVec(0, 4'b0001, 0, 4'b0000, 0, 0, 1, "to_pulse");
        addVec(0, 4'b0001, 0, 4'b1000, 0, 1, 0, "to_regrant");
        addVec(0, 4'b0001, 0, 4'b1000, 0, 1, 0, "tod_hold2");
        addVec(0, 4'b0001, 0, 4'b1000, 0, 1, 0, "tod_hold3");
        addVec(0, 4'b0001, 0, 4'b1000, 0, 1, 0, "tod_hold4");
        addVec(0, 4'b0001, 1, 4'b0000, 0, 0, 0, "tod_done_wins");
        addVec(0, 4'b0000, 0, 4'b0000, 0, 0, 0, "tod_idle");
        addVec(0, 4'b0010, 0, 4'b0100, 1, 1, 0, "ab_grant1");
        addVec(0, 4'b1001, 0, 4'b0000, 0, 0, 0, "ab_release");
        addVec(0, 4'b1001, 0, 4'b0001, 3, 1, 0, "ab_skip_to3");
        addVec(0, 4'b1001, 1, 4'b0000, 0, 0, 0, "ab_done");
        addVec(0, 4'b1001, 0, 4'b1000, 0, 1, 0, "mr_grant0");
        addVec(0, 4'b1001, 0, 4'b1000, 0, 1, 0, "mr_hold1");
        addVec(0, 4'b1001, 0, 4'b1000, 0, 1, 0, "mr_hold2");
        addVec(1, 4'b1111, 0, 4'b0000, 0, 0, 0, "mr_reset");
        addVec(0, 4'b1111, 0, 4'b1000, 0, 1, 0, "mr_first_grant0");
        addVec(0, 4'b1111, 1, 4'b0000, 0, 0, 0, "mr_done");

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // Free-running hold on requester 2: expect four grant cycles and then a timeout pulse.
        gcnt = 0;
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            rst  = 1'b0;
            req  = 4'b0100;
            done = 1'b0;
            @(posedge clk);
            #1;
            if (grant_valid) gcnt++;
            if (timeout) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL timeout_wait: got no timeout within 12 cycles, want a pulse");
        end
        checks++;
        if (gcnt != 4) begin
            errors++;
            $display("[TB] FAIL hold_length: got %0d grant cycles, want 4", gcnt);
        end

        // Holder drops its request on the would-be timeout cycle: abandon wins, no pulse.
        applyStimulus('{0, 4'b0001, 0, 4'b1000, 2'd0, 1, 0, "abt_grant0"});
        applyStimulus('{0, 4'b0001, 0, 4'b1000, 2'd0, 1, 0, "abt_hold2"});
        applyStimulus('{0, 4'b0001, 0, 4'b1000, 2'd0, 1, 0, "abt_hold3"});
        applyStimulus('{0, 4'b0001, 0, 4'b1000, 2'd0, 1, 0, "abt_hold4"});
        applyStimulus('{0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, "abt_no_timeout"});
        applyStimulus('{0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, "abt_idle"});

        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d leftover entries, want 0", expq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
